mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive data grants tolerated while fetch waits.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have fetch-side ports: if_req in 1; if_addr in ADDR_W; if_gnt out 1; if_rvalid out 1; if_rdata out DATA_W.
REQ-007 SHALL have data-side ports: d_req in 1; d_we in 1; d_wide in 1 (two-word access); d_addr in ADDR_W; d_wdata in 2*DATA_W; d_gnt out 1; d_done out 1; d_rdata out 2*DATA_W.
REQ-008 SHALL have memory-side ports: mem_rd out 1; mem_wr out 1; mem_raddr out ADDR_W; mem_waddr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid at the posedge ending the cycle mem_rd is high.

Function
REQ-009 SHALL share one single-ported memory between fetch (read-only, one word) and data (read/write, one or two words).
REQ-010 SHALL implement FSM states IDLE, BEAT0, BEAT1; IDLE->BEAT0 on any sampled request; BEAT0->BEAT1 if wide, else IDLE; BEAT1->IDLE.
REQ-011 SHALL latch winner, addr, we, wide, wdata on IDLE->BEAT0; requesters hold req/operands stable until gnt.
REQ-012 SHALL pulse if_gnt or d_gnt for exactly one cycle, in the BEAT0 cycle.
REQ-013 SHALL drive all mem_* outputs from registers; one memory strobe per beat cycle, zero in IDLE.
REQ-014 SHALL map wide accesses: beat0 at addr carries [2*DATA_W-1:DATA_W]; beat1 at addr+1 carries [DATA_W-1:0]; addr+1 wraps modulo 2^ADDR_W.
REQ-015 SHALL capture mem_rdata at the end of each read beat; if_rvalid/d_done pulse one cycle in the cycle after the last beat, with if_rdata/d_rdata valid then and held until the next response.
REQ-016 SHALL give narrow data reads zero-extended d_rdata in [DATA_W-1:0]; narrow writes use d_wdata[DATA_W-1:0].
REQ-017 SHALL pulse d_done for writes (narrow and wide) with the same timing as reads.
REQ-018 SHALL resolve simultaneous if_req and d_req in IDLE: data wins, except when the starvation guard forces fetch (REQ-024).
REQ-019 SHALL ignore requests outside IDLE; throughput is one access per (beats+1) cycles.
REQ-020 SHALL never assert mem_rd and mem_wr in the same cycle.

Reset
REQ-021 SHALL, on rst low at posedge: state IDLE; if_gnt, d_gnt, if_rvalid, d_done, mem_rd, mem_wr = 0; addresses, wdata, rdata outputs = 0; starvation counter = 0.
REQ-022 SHALL abort an access in progress on reset mid-operation: no beat1 and no response pulse after rst rises.

Configuration
REQ-023 SHALL support macro MEM_ARB_STARVE_GUARD_EN.
REQ-024 SHALL, with MEM_ARB_STARVE_GUARD_EN defined: count data grants issued while if_req high; clear on fetch grant or if_req low; when count == STARVE_MAX, the next arbitration grants fetch regardless of d_req.
REQ-025 SHALL, without the macro: strict data priority, no counter logic, STARVE_MAX unused.

Structure
REQ-026 SHALL place the FSM state typedef, a requester-id typedef (FETCH, DATA) and the beat-count constants in shared package mem_arb_pkg.
REQ-027 SHALL factor the priority decision and starvation counter into sub-module mem_arb_prio; the beat sequencer stays in mem_arbiter.

Verification
REQ-028 SHALL check: if_req alone, if_addr=0x00010, mem[0x10]=0xBEEF -> mem_rd 1 cycle at 0x10, if_gnt with it, if_rvalid next cycle with if_rdata=0xBEEF.
REQ-029 SHALL check: wide read d_addr=0xFFFFF, mem[0xFFFFF]=0x1234, mem[0]=0x5678 -> beats at 0xFFFFF then 0x00000, d_done with d_rdata=0x12345678.
REQ-030 SHALL check: wide write d_addr=0x40, d_wdata=0xCAFEF00D -> mem_wr at 0x40 with 0xCAFE, then 0x41 with 0xF00D, d_done once.
REQ-031 SHALL check: if_req and d_req held high continuously, guard enabled, STARVE_MAX=4 -> 4 data grants then 1 fetch grant, repeating; guard disabled -> fetch never granted.
REQ-032 SHALL check: rst low during BEAT0 of a wide read -> next cycle all strobes 0, state IDLE, no d_done ever pulses for that access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Imported by mem_arbiter and mem_arb_prio.
package mem_arb_pkg;

  // Beat sequencer state encoding
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_BEAT0 = 2'd1;
  localparam arb_state_t ST_BEAT1 = 2'd2;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  localparam int unsigned NARROW_BEATS = 1;
  localparam int unsigned WIDE_BEATS   = 2;

  // Number of memory beats an access occupies
  function automatic int unsigned num_beats(input logic wide);
    return wide ? WIDE_BEATS : NARROW_BEATS;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data priority decision, with optional fetch starvation guard.
// Guard built only when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
`ifdef MEM_ARB_STARVE_GUARD_EN
  input  logic    clk,
  input  logic    rst,
`endif
  input  logic    arb_en,
  input  logic    if_req,
  input  logic    d_req,
  output logic    grant_c,
  output req_id_t win_c
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             force_fetch_c;

  assign force_fetch_c = if_req && (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    grant_c = arb_en && (if_req || d_req);
    win_c   = (d_req && !force_fetch_c) ? REQ_DATA : REQ_FETCH;
  end

  // Counts data grants taken while fetch is waiting
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!if_req) begin
      cnt_q <= '0;
    end else if (grant_c) begin
      if (win_c == REQ_FETCH) cnt_q <= '0;
      else                    cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  always_comb begin
    grant_c = arb_en && (if_req || d_req);
    win_c   = d_req ? REQ_DATA : REQ_FETCH;
  end

  // STARVE_MAX is kept for a uniform parameter list; strict data priority here
  if (STARVE_MAX == 0) begin : g_starve_max_unused
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and a 1/2-word data port.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch side
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // data side
  input  logic                d_req,
  input  logic                d_we,
  input  logic                d_wide,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2*DATA_W-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_done,
  output logic [2*DATA_W-1:0] d_rdata,
  // memory side
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t          state_q, state_d;
  req_id_t             win_q, win_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                wide_q, wide_d;
  logic [DATA_W-1:0]   wdata_lo_q, wdata_lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;

  logic                if_gnt_d, d_gnt_d, if_rvalid_d, d_done_d;
  logic [DATA_W-1:0]   if_rdata_d;
  logic [2*DATA_W-1:0] d_rdata_d;
  logic                mem_rd_d, mem_wr_d;
  logic [ADDR_W-1:0]   mem_raddr_d, mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  logic                arb_grant_c;
  req_id_t             arb_win_c;
  logic [ADDR_W-1:0]   next_addr_c;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
`ifdef MEM_ARB_STARVE_GUARD_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .arb_en  (state_q == ST_IDLE),
    .if_req  (if_req),
    .d_req   (d_req),
    .grant_c (arb_grant_c),
    .win_c   (arb_win_c)
  );

  assign next_addr_c = addr_q + ADDR_W'(1);

  // Next-state and next-output logic for the beat sequencer
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wide_d      = wide_q;
    wdata_lo_d  = wdata_lo_q;
    hi_d        = hi_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_raddr_d = mem_raddr;
    mem_waddr_d = mem_waddr;
    mem_wdata_d = mem_wdata;

    case (state_q)
      ST_IDLE: begin
        if (arb_grant_c) begin
          state_d = ST_BEAT0;
          win_d   = arb_win_c;
          if (arb_win_c == REQ_FETCH) begin
            addr_d      = if_addr;
            we_d        = 1'b0;
            wide_d      = 1'b0;
            if_gnt_d    = 1'b1;
            mem_rd_d    = 1'b1;
            mem_raddr_d = if_addr;
          end else begin
            addr_d     = d_addr;
            we_d       = d_we;
            wide_d     = d_wide;
            wdata_lo_d = d_wdata[DATA_W-1:0];
            d_gnt_d    = 1'b1;
            if (d_we) begin
              mem_wr_d    = 1'b1;
              mem_waddr_d = d_addr;
              // wide writes send the upper word first
              mem_wdata_d = d_wide ? d_wdata[2*DATA_W-1:DATA_W] : d_wdata[DATA_W-1:0];
            end else begin
              mem_rd_d    = 1'b1;
              mem_raddr_d = d_addr;
            end
          end
        end
      end

      ST_BEAT0: begin
        if (num_beats(wide_q) > NARROW_BEATS) begin
          state_d = ST_BEAT1;
          hi_d    = mem_rdata;
          if (we_q) begin
            mem_wr_d    = 1'b1;
            mem_waddr_d = next_addr_c;
            mem_wdata_d = wdata_lo_q;
          end else begin
            mem_rd_d    = 1'b1;
            mem_raddr_d = next_addr_c;
          end
        end else begin
          state_d = ST_IDLE;
          if (win_q == REQ_FETCH) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!we_q) d_rdata_d = (2*DATA_W)'(mem_rdata);
          end
        end
      end

      ST_BEAT1: begin
        state_d  = ST_IDLE;
        d_done_d = 1'b1;
        if (!we_q) d_rdata_d = {hi_q, mem_rdata};
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset also aborts any access in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      win_q      <= REQ_FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wide_q     <= 1'b0;
      wdata_lo_q <= '0;
      hi_q       <= '0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_rvalid  <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wide_q     <= wide_d;
      wdata_lo_q <= wdata_lo_d;
      hi_q       <= hi_d;
      if_gnt     <= if_gnt_d;
      d_gnt      <= d_gnt_d;
      if_rvalid  <= if_rvalid_d;
      d_done     <= d_done_d;
      if_rdata   <= if_rdata_d;
      d_rdata    <= d_rdata_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_raddr  <= mem_raddr_d;
      mem_waddr  <= mem_waddr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, starvation and
// mid-access reset sequences, then randomized accesses against a word-level model.
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [19:0] if_addr;
  logic [15:0] if_rdata;
  logic        d_req, d_we, d_wide, d_gnt, d_done;
  logic [19:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_rd, mem_wr;
  logic [19:0] mem_raddr, mem_waddr;
  logic [15:0] mem_wdata, mem_rdata;

  logic        pl_en;
  logic [19:0] pl_addr;
  logic [15:0] pl_data;

  logic [15:0] mem [0:1048575];
  logic [15:0] ref_mem [logic [19:0]];

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        fq;
    logic [19:0] fa;
    logic        dq;
    logic        we;
    logic        wide;
    logic [19:0] da;
    logic [31:0] wd;
    logic        edata;
    logic [19:0] ea0;
    logic [19:0] ea1;
    logic [15:0] ew0;
    logic [15:0] ew1;
    logic [31:0] erd;
  } vec_t;

  mem_arbiter #(.ADDR_W(20), .DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wide(d_wide), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: writes from the DUT or from the bench preload port
  always @(posedge clk) begin
    if (mem_wr) mem[mem_waddr] <= mem_wdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end
  assign mem_rdata = mem[mem_raddr];

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
  endtask

  always @(negedge clk)
    if (rst && (mem_rd || mem_wr)) chk("mon", "rd_wr_exclusive", 32'(mem_rd && mem_wr), 32'd0);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drop_reqs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wide = 1'b0;
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  // One access from idle: grant, beat strobes, response pulse, pulse release
  task automatic run_vec(input vec_t v, input int id);
    string tag;
    bit    got, isd, iswr, isw;
    int    cyc;
    tag  = $sformatf("vec%0d", id);
    isd  = v.edata;
    iswr = isd && v.we;
    isw  = isd && v.wide;
    if_req = v.fq; if_addr = v.fa;
    d_req = v.dq; d_we = v.we; d_wide = v.wide; d_addr = v.da; d_wdata = v.wd;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 4) begin
      step(); cyc++; got = if_gnt || d_gnt;
    end
    chk(tag, "gnt_latency", 32'(cyc), 32'd1);
    if (!got) begin
      drop_reqs(); repeat (4) @(posedge clk); #1;
      return;
    end
    chk(tag, "if_gnt", 32'(if_gnt), 32'(!isd));
    chk(tag, "d_gnt", 32'(d_gnt), 32'(isd));
    chk(tag, "beat0_rd", 32'(mem_rd), 32'(!iswr));
    chk(tag, "beat0_wr", 32'(mem_wr), 32'(iswr));
    chk(tag, "beat0_addr", 32'(iswr ? mem_waddr : mem_raddr), 32'(v.ea0));
    if (iswr) chk(tag, "beat0_wdata", 32'(mem_wdata), 32'(v.ew0));
    drop_reqs();
    if (isw) begin
      step();
      chk(tag, "beat1_gnt", 32'(if_gnt || d_gnt), 32'd0);
      chk(tag, "beat1_rd", 32'(mem_rd), 32'(!iswr));
      chk(tag, "beat1_wr", 32'(mem_wr), 32'(iswr));
      chk(tag, "beat1_addr", 32'(iswr ? mem_waddr : mem_raddr), 32'(v.ea1));
      if (iswr) chk(tag, "beat1_wdata", 32'(mem_wdata), 32'(v.ew1));
      chk(tag, "early_done", 32'(d_done), 32'd0);
    end
    step();
    chk(tag, "if_rvalid", 32'(if_rvalid), 32'(!isd));
    chk(tag, "d_done", 32'(d_done), 32'(isd));
    chk(tag, "resp_strobe", 32'(mem_rd || mem_wr), 32'd0);
    if (!isd) chk(tag, "if_rdata", 32'(if_rdata), 32'(v.erd[15:0]));
    else if (!v.we) chk(tag, "d_rdata", d_rdata, v.erd);
    step();
    chk(tag, "resp_release", 32'(if_rvalid || d_done), 32'd0);
  endtask

  function automatic logic [19:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    return (r < 8) ? 20'(r) : 20'hFFFF0 + 20'(r);
  endfunction

  vec_t vt [9];

  initial begin
    vt[0] = '{fq:1'b1, fa:20'h00010, dq:1'b0, we:1'b0, wide:1'b0, da:20'h0, wd:32'h0,
              edata:1'b0, ea0:20'h00010, ea1:20'h0, ew0:16'h0, ew1:16'h0, erd:32'h0000BEEF};
    vt[1] = '{fq:1'b0, fa:20'h0, dq:1'b1, we:1'b0, wide:1'b1, da:20'hFFFFF, wd:32'h0,
              edata:1'b1, ea0:20'hFFFFF, ea1:20'h00000, ew0:16'h0, ew1:16'h0, erd:32'h12345678};
    vt[2] = '{fq:1'b0, fa:20'h0, dq:1'b1, we:1'b1, wide:1'b1, da:20'h00040, wd:32'hCAFEF00D,
              edata:1'b1, ea0:20'h00040, ea1:20'h00041, ew0:16'hCAFE, ew1:16'hF00D, erd:32'h0};
    vt[3] = '{fq:1'b1, fa:20'h00010, dq:1'b1, we:1'b0, wide:1'b0, da:20'h00020, wd:32'h0,
              edata:1'b1, ea0:20'h00020, ea1:20'h0, ew0:16'h0, ew1:16'h0, erd:32'h0000A5A5};
    vt[4] = '{fq:1'b0, fa:20'h0, dq:1'b1, we:1'b1, wide:1'b0, da:20'h00030, wd:32'h11112222,
              edata:1'b1, ea0:20'h00030, ea1:20'h0, ew0:16'h2222, ew1:16'h0, erd:32'h0};
    vt[5] = '{fq:1'b0, fa:20'h0, dq:1'b1, we:1'b0, wide:1'b0, da:20'h00030, wd:32'h0,
              edata:1'b1, ea0:20'h00030, ea1:20'h0, ew0:16'h0, ew1:16'h0, erd:32'h00002222};
    vt[6] = '{fq:1'b0, fa:20'h0, dq:1'b1, we:1'b0, wide:1'b1, da:20'h00040, wd:32'h0,
              edata:1'b1, ea0:20'h00040, ea1:20'h00041, ew0:16'h0, ew1:16'h0, erd:32'hCAFEF00D};
    vt[7] = '{fq:1'b0, fa:20'h0, dq:1'b1, we:1'b1, wide:1'b1, da:20'hFFFFF, wd:32'hAAAA5555,
              edata:1'b1, ea0:20'hFFFFF, ea1:20'h00000, ew0:16'hAAAA, ew1:16'h5555, erd:32'h0};
    vt[8] = '{fq:1'b1, fa:20'h00000, dq:1'b0, we:1'b0, wide:1'b0, da:20'h0, wd:32'h0,
              edata:1'b0, ea0:20'h00000, ea1:20'h0, ew0:16'h0, ew1:16'h0, erd:32'h00005555};

    // Reset dominates pending requests
    rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    if_req = 1'b1; if_addr = 20'h12345; d_req = 1'b1; d_we = 1'b1; d_wide = 1'b1;
    d_addr = 20'h54321; d_wdata = 32'hDEADBEEF;
    repeat (3) step();
    chk("reset", "if_gnt", 32'(if_gnt), 32'd0);
    chk("reset", "d_gnt", 32'(d_gnt), 32'd0);
    chk("reset", "pulses", 32'(if_rvalid || d_done), 32'd0);
    chk("reset", "strobes", 32'(mem_rd || mem_wr), 32'd0);
    chk("reset", "mem_raddr", 32'(mem_raddr), 32'd0);
    chk("reset", "mem_waddr", 32'(mem_waddr), 32'd0);
    chk("reset", "mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset", "if_rdata", 32'(if_rdata), 32'd0);
    chk("reset", "d_rdata", d_rdata, 32'd0);
    drop_reqs(); d_wdata = '0; if_addr = '0; d_addr = '0;
    rst = 1'b1;
    step();

    preload(20'h00010, 16'hBEEF);
    preload(20'hFFFFF, 16'h1234);
    preload(20'h00000, 16'h5678);
    preload(20'h00020, 16'hA5A5);
    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Both requesters held high: data wins until the guard forces fetch
    begin
      bit got, exp_f;
      int cyc;
      if_req = 1'b1; if_addr = 20'h00010; d_req = 1'b1; d_we = 1'b0; d_wide = 1'b0; d_addr = 20'h00020;
      for (int k = 0; k < 10; k++) begin
        got = 1'b0; cyc = 0;
        while (!got && cyc < 4) begin
          step(); cyc++; got = if_gnt || d_gnt;
        end
        chk("starve", $sformatf("grant%0d_seen", k), 32'(got), 32'd1);
        if (!got) break;
        exp_f = GUARD && ((k % (STARVE_MAX + 1)) == STARVE_MAX);
        chk("starve", $sformatf("grant%0d_fetch", k), 32'(if_gnt), 32'(exp_f));
        chk("starve", $sformatf("grant%0d_data", k), 32'(d_gnt), 32'(!exp_f));
      end
      drop_reqs();
      repeat (3) step();
    end

    // Reset during the first beat of a wide read
    begin
      bit got;
      int cyc, late;
      d_req = 1'b1; d_we = 1'b0; d_wide = 1'b1; d_addr = 20'h00040;
      got = 1'b0; cyc = 0;
      while (!got && cyc < 4) begin
        step(); cyc++; got = d_gnt;
      end
      chk("rstmid", "d_gnt", 32'(got), 32'd1);
      chk("rstmid", "beat0_rd", 32'(mem_rd), 32'd1);
      drop_reqs();
      rst = 1'b0;
      step();
      chk("rstmid", "strobes", 32'(mem_rd || mem_wr), 32'd0);
      chk("rstmid", "pulses", 32'(d_done || if_rvalid || d_gnt || if_gnt), 32'd0);
      chk("rstmid", "mem_raddr", 32'(mem_raddr), 32'd0);
      rst = 1'b1;
      late = 0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (d_done || mem_rd || mem_wr) late++;
      end
      chk("rstmid", "activity_after_reset", 32'(late), 32'd0);
      run_vec(vt[0], 50);
    end

    // Randomized accesses against a word-addressed reference memory
    for (int i = 0; i < 9; i++) preload(20'(i), 16'($urandom));
    for (int i = 0; i < 8; i++) preload(20'hFFFF8 + 20'(i), 16'($urandom));
    for (int t = 0; t < 60; t++) begin
      vec_t v;
      v.fq   = 1'($urandom_range(0, 1));
      v.dq   = v.fq ? 1'($urandom_range(0, 1)) : 1'b1;
      v.fa   = pick_addr();
      v.da   = pick_addr();
      v.we   = 1'($urandom_range(0, 1));
      v.wide = 1'($urandom_range(0, 1));
      v.wd   = $urandom;
      v.edata = v.dq;
      v.ea0  = v.edata ? v.da : v.fa;
      v.ea1  = v.da + 20'd1;
      v.ew0  = v.wide ? v.wd[31:16] : v.wd[15:0];
      v.ew1  = v.wd[15:0];
      v.erd  = 32'h0;
      if (!v.edata) begin
        v.erd = {16'h0, ref_mem[v.fa]};
      end else if (!v.we) begin
        v.erd = v.wide ? {ref_mem[v.da], ref_mem[v.da + 20'd1]} : {16'h0, ref_mem[v.da]};
      end else begin
        ref_mem[v.da] = v.ew0;
        if (v.wide) ref_mem[v.da + 20'd1] = v.ew1;
      end
      run_vec(v, 100 + t);
    end

    for (int i = 0; i < 9; i++)
      chk("final", $sformatf("mem_%05h", i), 32'(mem[20'(i)]), 32'(ref_mem[20'(i)]));
    for (int i = 0; i < 8; i++)
      chk("final", $sformatf("mem_%05h", 20'hFFFF8 + 20'(i)),
          32'(mem[20'hFFFF8 + 20'(i)]), 32'(ref_mem[20'hFFFF8 + 20'(i)]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
